param_reservation_station: RTL

//  Parametrised command reservation station between the command decoder and the ld/ex/st units.

---
 rtl/param_reservation_station_if.sv | 79 +++++++
 rtl/param_reservation_station.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/param_reservation_station_if.sv
// -----------------------------------------------------------------------------
// param_reservation_station_if
//   Bundles the command-side and unit-side handshakes of the reservation
//   station so the station and its neighbours connect through one port.
//
//   Alloc     : io_alloc_valid/ready plus the decoded command fields.
//   Completion: io_completed_valid with the robId of the finished command.
//   Issue     : one valid/ready channel per queue (ld, ex, st).  Each channel
//               carries the command (cmd), the slot index (robId) and a debug
//               sequence tag (seq).
//               cmd layout, MSB first:
//                 {qType[1:0], opaIsDst,
//                  opa{valid, start[ADDR_W], len[LEN_W]},
//                  opb{valid, start[ADDR_W], len[LEN_W]}}
//   Status    : io_busy, io_count, io_err.
//
//   master = command decoder / execution units side, slave = station side.
// -----------------------------------------------------------------------------
interface param_reservation_station_if #(
   parameter int ROB_W  = 3,
   parameter int ADDR_W = 16,
   parameter int LEN_W  = 16
);
   localparam int CMD_W = 3 + 2 * (1 + ADDR_W + LEN_W);

   logic              io_alloc_valid;
   logic              io_alloc_ready;
   logic [1:0]        io_alloc_bits_qType;
   logic              io_alloc_bits_opa_valid;
   logic [ADDR_W-1:0] io_alloc_bits_opa_start;
   logic [LEN_W-1:0]  io_alloc_bits_opa_len;
   logic              io_alloc_bits_opb_valid;
   logic [ADDR_W-1:0] io_alloc_bits_opb_start;
   logic [LEN_W-1:0]  io_alloc_bits_opb_len;
   logic              io_alloc_bits_opaIsDst;

   logic              io_completed_valid;
   logic [ROB_W-1:0]  io_completed_bits;

   logic              io_issue_ld_valid, io_issue_ex_valid, io_issue_st_valid;
   logic              io_issue_ld_ready, io_issue_ex_ready, io_issue_st_ready;
   logic [CMD_W-1:0]  io_issue_ld_cmd,   io_issue_ex_cmd,   io_issue_st_cmd;
   logic [ROB_W-1:0]  io_issue_ld_robId, io_issue_ex_robId, io_issue_st_robId;
   logic [ROB_W:0]    io_issue_ld_seq,   io_issue_ex_seq,   io_issue_st_seq;

   logic              io_busy;
   logic [ROB_W:0]    io_count;
   logic              io_err;

   modport master (
      output io_alloc_valid, io_alloc_bits_qType,
             io_alloc_bits_opa_valid, io_alloc_bits_opa_start, io_alloc_bits_opa_len,
             io_alloc_bits_opb_valid, io_alloc_bits_opb_start, io_alloc_bits_opb_len,
             io_alloc_bits_opaIsDst,
             io_completed_valid, io_completed_bits,
             io_issue_ld_ready, io_issue_ex_ready, io_issue_st_ready,
      input  io_alloc_ready,
             io_issue_ld_valid, io_issue_ex_valid, io_issue_st_valid,
             io_issue_ld_cmd, io_issue_ex_cmd, io_issue_st_cmd,
             io_issue_ld_robId, io_issue_ex_robId, io_issue_st_robId,
             io_issue_ld_seq, io_issue_ex_seq, io_issue_st_seq,
             io_busy, io_count, io_err
   );

   modport slave (
      input  io_alloc_valid, io_alloc_bits_qType,
             io_alloc_bits_opa_valid, io_alloc_bits_opa_start, io_alloc_bits_opa_len,
             io_alloc_bits_opb_valid, io_alloc_bits_opb_start, io_alloc_bits_opb_len,
             io_alloc_bits_opaIsDst,
             io_completed_valid, io_completed_bits,
             io_issue_ld_ready, io_issue_ex_ready, io_issue_st_ready,
      output io_alloc_ready,
             io_issue_ld_valid, io_issue_ex_valid, io_issue_st_valid,
             io_issue_ld_cmd, io_issue_ex_cmd, io_issue_st_cmd,
             io_issue_ld_robId, io_issue_ex_robId, io_issue_st_robId,
             io_issue_ld_seq, io_issue_ex_seq, io_issue_st_seq,
             io_busy, io_count, io_err
   );
endinterface

// File: rtl/param_reservation_station.sv
// -----------------------------------------------------------------------------
// param_reservation_station
//   Holds up to ENTRIES decoded commands for the ld/ex/st units, tracks
//   scratchpad address-range hazards (RAW/WAR/WAW) between them, issues the
//   oldest hazard-free command of each queue and frees a slot when its unit
//   reports completion by robId (= slot index).
//
// Ports
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   rs    : param_reservation_station_if.slave (alloc, completion, three
//           issue channels, busy/count/err status)
//
// qType encoding: 0 = ld, 1 = ex, 2 = st, 3 = illegal (accepted and dropped).
// -----------------------------------------------------------------------------
module param_reservation_station #(
   parameter int ENTRIES = 8,
   parameter int ROB_W   = 3,
   parameter int ADDR_W  = 16,
   parameter int LEN_W   = 16
) (
   input logic                         clock,
   input logic                         reset,
   param_reservation_station_if.slave  rs
);
   localparam int NQ = 3;

   typedef struct packed {
      logic              vld;
      logic [ADDR_W-1:0] start;
      logic [LEN_W-1:0]  len;
   } op_t;

   typedef struct packed {
      logic [1:0] qtype;
      logic       opa_is_dst;
      op_t        opa;
      op_t        opb;
   } cmd_t;

   // An operand only takes part in hazard checks when valid with non-zero length.
   function automatic logic overlap(op_t a, op_t b);
      logic [ADDR_W:0] a_end, b_end;
      a_end = (ADDR_W+1)'(a.start) + (ADDR_W+1)'(a.len);
      b_end = (ADDR_W+1)'(b.start) + (ADDR_W+1)'(b.len);
      return a.vld && (a.len != '0) && b.vld && (b.len != '0) &&
             ((ADDR_W+1)'(a.start) < b_end) && ((ADDR_W+1)'(b.start) < a_end);
   endfunction

   // opa is the destination when opaIsDst, otherwise an extra read operand.
   function automatic logic hazard(cmd_t n, cmd_t j);
      op_t n_dst, n_rd, j_dst, j_rd;
      n_dst = n.opa_is_dst ? n.opa : '0;
      n_rd  = n.opa_is_dst ? '0    : n.opa;
      j_dst = j.opa_is_dst ? j.opa : '0;
      j_rd  = j.opa_is_dst ? '0    : j.opa;
      return overlap(n_dst, j_dst) || overlap(n_dst, j_rd) || overlap(n_dst, j.opb) ||
             overlap(n_rd, j_dst)  || overlap(n.opb, j_dst);
   endfunction

   logic [ENTRIES-1:0]              valid_q, valid_d, issued_q, issued_d;
   logic [ENTRIES-1:0]              flush_q, flush_d;
   logic [ENTRIES-1:0][ENTRIES-1:0] dep_q, dep_d, ord_q, ord_d;
   cmd_t                            cmd_q [ENTRIES];
   cmd_t                            cmd_d [ENTRIES];
   logic [ROB_W:0]                  seq_q [ENTRIES];
   logic [ROB_W:0]                  seq_d [ENTRIES];
   logic [ROB_W:0]                  seq_ctr_q, seq_ctr_d;
   logic [ROB_W:0]                  count_q, count_d;
   logic                            err_q, err_d;

   logic                            any_free, alloc_fire, alloc_wr;
   logic [ROB_W-1:0]                free_idx;
   cmd_t                            new_cmd;
   logic [NQ-1:0]                   issue_vld, issue_rdy, issue_fire;
   logic [ROB_W-1:0]                issue_idx [NQ];
   logic [ENTRIES-1:0]              issuing, completing;
   logic [ROB_W-1:0]                comp_r;
   logic                            comp_hit, comp_ok, comp_stale, comp_bad;

   assign new_cmd = '{qtype:      rs.io_alloc_bits_qType,
                      opa_is_dst: rs.io_alloc_bits_opaIsDst,
                      opa: '{vld: rs.io_alloc_bits_opa_valid, start: rs.io_alloc_bits_opa_start,
                             len: rs.io_alloc_bits_opa_len},
                      opb: '{vld: rs.io_alloc_bits_opb_valid, start: rs.io_alloc_bits_opb_start,
                             len: rs.io_alloc_bits_opb_len}};

   assign issue_rdy = {rs.io_issue_st_ready, rs.io_issue_ex_ready, rs.io_issue_ld_ready};

   // Lowest free slot from registered state; a slot freed this cycle waits a cycle.
   always_comb begin
      any_free = 1'b0;
      free_idx = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            any_free = 1'b1;
            free_idx = ROB_W'(i);
         end
      end
   end

   assign rs.io_alloc_ready = any_free && !reset;
   assign alloc_fire        = rs.io_alloc_valid && rs.io_alloc_ready;
   assign alloc_wr          = alloc_fire && (new_cmd.qtype != 2'd3);

   // Per-queue selection; ord keeps at most one candidate per queue.
   always_comb begin
      issuing = '0;
      for (int q = 0; q < NQ; q++) begin
         issue_vld[q] = 1'b0;
         issue_idx[q] = '0;
         for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && !issued_q[i] && (dep_q[i] == '0) && (ord_q[i] == '0) &&
                (cmd_q[i].qtype == 2'(q)) && !reset) begin
               issue_vld[q] = 1'b1;
               issue_idx[q] = ROB_W'(i);
            end
         end
         issue_fire[q] = issue_vld[q] && issue_rdy[q];
         if (issue_fire[q]) issuing[issue_idx[q]] = 1'b1;
      end
   end

   // Completions to a slot that was in flight when reset hit (flush) are
   // swallowed silently; any other completion to a non-issued slot is an error.
   assign comp_r     = rs.io_completed_bits;
   assign comp_hit   = valid_q[comp_r] && issued_q[comp_r];
   assign comp_ok    = rs.io_completed_valid && comp_hit;
   assign comp_stale = rs.io_completed_valid && !comp_hit && flush_q[comp_r];
   assign comp_bad   = rs.io_completed_valid && !comp_hit && !flush_q[comp_r];

   always_comb begin
      completing = '0;
      if (comp_ok) completing[comp_r] = 1'b1;
   end

   always_comb begin
      valid_d   = valid_q;
      issued_d  = issued_q | issuing;
      flush_d   = flush_q;
      dep_d     = dep_q;
      ord_d     = ord_q;
      cmd_d     = cmd_q;
      seq_d     = seq_q;
      seq_ctr_d = seq_ctr_q;
      for (int q = 0; q < NQ; q++) begin
         if (issue_fire[q]) begin
            for (int i = 0; i < ENTRIES; i++) ord_d[i][issue_idx[q]] = 1'b0;
         end
      end
      if (comp_ok) begin
         valid_d[comp_r]  = 1'b0;
         issued_d[comp_r] = 1'b0;
         for (int i = 0; i < ENTRIES; i++) dep_d[i][comp_r] = 1'b0;
      end
      if (comp_stale) flush_d[comp_r] = 1'b0;
      if (alloc_wr) begin
         valid_d[free_idx]  = 1'b1;
         issued_d[free_idx] = 1'b0;
         flush_d[free_idx]  = 1'b0;
         cmd_d[free_idx]    = new_cmd;
         seq_d[free_idx]    = seq_ctr_q;
         seq_ctr_d          = seq_ctr_q + (ROB_W+1)'(1);
         for (int j = 0; j < ENTRIES; j++) begin
            dep_d[free_idx][j] = valid_q[j] && !completing[j] && hazard(new_cmd, cmd_q[j]);
            ord_d[free_idx][j] = valid_q[j] && !issued_q[j] && !issuing[j] &&
                                 (cmd_q[j].qtype == new_cmd.qtype);
         end
      end
      count_d = count_q + (ROB_W+1)'(alloc_wr) - (ROB_W+1)'(comp_ok);
      err_d   = err_q || comp_bad || (alloc_fire && (new_cmd.qtype == 2'd3));
   end

   // Flush accumulates across a multi-cycle reset so the first reset cycle's
   // in-flight set is not lost once valid has been cleared.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q   <= '0;
         issued_q  <= '0;
         flush_q   <= flush_q | (valid_q & issued_q);
         dep_q     <= '0;
         ord_q     <= '0;
         seq_ctr_q <= '0;
         count_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         issued_q  <= issued_d;
         flush_q   <= flush_d;
         dep_q     <= dep_d;
         ord_q     <= ord_d;
         seq_ctr_q <= seq_ctr_d;
         count_q   <= count_d;
         err_q     <= err_d;
      end
      cmd_q <= cmd_d;
      seq_q <= seq_d;
   end

   assign rs.io_issue_ld_valid = issue_vld[0];
   assign rs.io_issue_ex_valid = issue_vld[1];
   assign rs.io_issue_st_valid = issue_vld[2];
   assign rs.io_issue_ld_robId = issue_idx[0];
   assign rs.io_issue_ex_robId = issue_idx[1];
   assign rs.io_issue_st_robId = issue_idx[2];
   assign rs.io_issue_ld_cmd   = cmd_q[issue_idx[0]];
   assign rs.io_issue_ex_cmd   = cmd_q[issue_idx[1]];
   assign rs.io_issue_st_cmd   = cmd_q[issue_idx[2]];
   assign rs.io_issue_ld_seq   = seq_q[issue_idx[0]];
   assign rs.io_issue_ex_seq   = seq_q[issue_idx[1]];
   assign rs.io_issue_st_seq   = seq_q[issue_idx[2]];
   assign rs.io_busy           = |valid_q;
   assign rs.io_count          = count_q;
   assign rs.io_err            = err_q;
endmodule
